// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register busy scoreboard and pending count
//
// Optional macro: REGFILE_BYPASS_EN enables write-through forwarding on both read ports.
//
// Ports:
//   Clk, Reset      clock, asynchronous active-high reset
//   DR, D_in        writeback index and data
//   LD_REG          writeback enable (also clears busy[DR])
//   RSV, RSV_DR     reserve request and target (sets busy[RSV_DR] when accepted)
//   SR1_in, SR2_in  read indices
//   SR1_out/SR2_out combinational read data
//   SR1_busy/SR2_busy busy bit of the read register
//   RSV_ok          reserve accepted this cycle (combinational)
//   Pending_cnt     number of busy registers (registered)
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] DR,
  input  logic [DATA_W-1:0] D_in,
  input  logic              LD_REG,
  input  logic              RSV,
  input  logic [ADDR_W-1:0] RSV_DR,
  input  logic [ADDR_W-1:0] SR1_in,
  input  logic [ADDR_W-1:0] SR2_in,
  output logic [DATA_W-1:0] SR1_out,
  output logic [DATA_W-1:0] SR2_out,
  output logic              SR1_busy,
  output logic              SR2_busy,
  output logic              RSV_ok,
  output logic [ADDR_W:0]   Pending_cnt
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]                 cnt_q, cnt_d;
  logic                            rsv_acc;
  logic                            wb_clear;

  always_comb begin
    // Reserve is judged against the pre-edge busy bit, so a WAW reserve is
    // rejected even when a writeback to the same register lands this edge.
    rsv_acc  = RSV & ~busy_q[RSV_DR];
    wb_clear = LD_REG & busy_q[DR];

    regs_d = regs_q;
    if (LD_REG) regs_d[DR] = D_in;

    // Set has priority over clear: an accepted reserve alongside a writeback
    // to the same (idle) register leaves it busy.
    busy_d = busy_q;
    if (LD_REG)  busy_d[DR]     = 1'b0;
    if (rsv_acc) busy_d[RSV_DR] = 1'b1;

    cnt_d = cnt_q;
    if (rsv_acc && !wb_clear)      cnt_d = cnt_q + 1'b1;
    else if (!rsv_acc && wb_clear) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RSV_ok      = rsv_acc;
  assign Pending_cnt = cnt_q;

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;

  // Forwarding is suppressed during reset so reads return zero.
  always_comb begin
    fwd1 = !Reset && LD_REG && (DR == SR1_in);
    fwd2 = !Reset && LD_REG && (DR == SR2_in);
    SR1_out  = fwd1 ? D_in : regs_q[SR1_in];
    SR2_out  = fwd2 ? D_in : regs_q[SR2_in];
    SR1_busy = fwd1 ? (rsv_acc && (RSV_DR == SR1_in)) : busy_q[SR1_in];
    SR2_busy = fwd2 ? (rsv_acc && (RSV_DR == SR2_in)) : busy_q[SR2_in];
  end
`else
  always_comb begin
    SR1_out  = regs_q[SR1_in];
    SR2_out  = regs_q[SR2_in];
    SR1_busy = busy_q[SR1_in];
    SR2_busy = busy_q[SR2_in];
  end
`endif

endmodule
